// File: rtl/btn_pkg.sv
// Shared constants for the push-button debouncer family.
// Cycle counts assume the 100 MHz system clock.
package btn_pkg;
    localparam int CLK_HZ         = 100_000_000;
    localparam int DEBOUNCE_20MS  = 2_000_000;
    localparam int LONG_1S        = 100_000_000;
    localparam int DEFAULT_NUM_CH = 5;
endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-FF synchroniser, glitch-rejecting debounce
// counter, registered rise/fall pulses and a saturating long-press detector.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int   LONG_CYCLES     = LONG_1S,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic button_out,
    output logic button_rise,
    output logic button_fall,
    output logic button_long,
    output logic button_held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES) + 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);

    logic          s1;
    logic          s2;
    logic          out_d;
    logic [CW-1:0] cnt;
    logic [LW-1:0] long_cnt;
    logic          pressed;

    // "Pressed" is relative to the idle level so active-low buttons work too.
    assign pressed = (button_out != RESET_LEVEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= RESET_LEVEL;
            s2          <= RESET_LEVEL;
            button_out  <= RESET_LEVEL;
            out_d       <= RESET_LEVEL;
            cnt         <= '0;
            long_cnt    <= '0;
            button_rise <= 1'b0;
            button_fall <= 1'b0;
            button_long <= 1'b0;
            button_held <= 1'b0;
        end else begin
            s1 <= button_in;
            s2 <= s1;

            // Any agreement before terminal count throws the progress away.
            if (s2 == button_out) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                button_out <= s2;
                cnt        <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            out_d       <= button_out;
            button_rise <= button_out & ~out_d;
            button_fall <= ~button_out & out_d;

            if (!pressed) begin
                long_cnt    <= '0;
                button_long <= 1'b0;
                button_held <= 1'b0;
            end else begin
                button_long <= (long_cnt == LONG_LAST);
                if (long_cnt == LONG_LAST) begin
                    button_held <= 1'b1;
                end
                // Saturating so the long pulse fires once per press.
                if (long_cnt != LONG_MAX) begin
                    long_cnt <= long_cnt + LW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/button_debounce_multi.sv
// N independent push-button debouncers; each channel owns all of its state.
// Channels are replicated with no sharing and no arbitration.
module button_debounce_multi
    import btn_pkg::*;
#(
    parameter int   NUM_CH          = DEFAULT_NUM_CH,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int   LONG_CYCLES     = LONG_1S,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] button_in,
    output logic [NUM_CH-1:0] button_out,
    output logic [NUM_CH-1:0] button_rise,
    output logic [NUM_CH-1:0] button_fall,
    output logic [NUM_CH-1:0] button_long,
    output logic [NUM_CH-1:0] button_held
);
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .button_in   (button_in[ch]),
            .button_out  (button_out[ch]),
            .button_rise (button_rise[ch]),
            .button_fall (button_fall[ch]),
            .button_long (button_long[ch]),
            .button_held (button_held[ch])
        );
    end
endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi (3 channels, short counts) with a
// timestamp-based reference model checked every cycle.
module tb_button_debounce_multi;
    localparam int NCH  = 3;
    localparam int DEB  = 8;
    localparam int LONG = 20;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] button_in;
    logic [NCH-1:0] button_out;
    logic [NCH-1:0] button_rise;
    logic [NCH-1:0] button_fall;
    logic [NCH-1:0] button_long;
    logic [NCH-1:0] button_held;

    int n_checks = 0;
    int n_fail   = 0;

    button_debounce_multi #(
        .NUM_CH          (NCH),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_in   (button_in),
        .button_out  (button_out),
        .button_rise (button_rise),
        .button_fall (button_fall),
        .button_long (button_long),
        .button_held (button_held)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model. Edges are numbered from reset release. The level flips
    // once the synchronised input has disagreed with it for DEB edges in a row
    // (tracked as the last edge where they agreed); a press is timestamped and
    // its age decides the long pulse and the held flag.
    int             ec;
    logic [NCH-1:0] m_s1, m_s2, m_out, m_out_prev;
    logic [NCH-1:0] m_rise, m_fall, m_long, m_held;
    int             agree_e [NCH];
    int             press_e [NCH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ec         <= 0;
            m_s1       <= '0;
            m_s2       <= '0;
            m_out      <= '0;
            m_out_prev <= '0;
            m_rise     <= '0;
            m_fall     <= '0;
            m_long     <= '0;
            m_held     <= '0;
            for (int c = 0; c < NCH; c++) begin
                agree_e[c] <= 0;
                press_e[c] <= 0;
            end
        end else begin
            ec         <= ec + 1;
            m_s1       <= button_in;
            m_s2       <= m_s1;
            m_out_prev <= m_out;
            m_rise     <= m_out & ~m_out_prev;
            m_fall     <= ~m_out & m_out_prev;
            for (int c = 0; c < NCH; c++) begin
                if (m_s2[c] == m_out[c]) begin
                    agree_e[c] <= ec + 1;
                end else if ((ec + 1) - agree_e[c] == DEB) begin
                    m_out[c]   <= m_s2[c];
                    agree_e[c] <= ec + 1;
                    if (m_s2[c]) press_e[c] <= ec + 1;
                end
                if (m_out[c]) begin
                    m_long[c] <= ((ec + 1) - press_e[c] == LONG);
                    m_held[c] <= ((ec + 1) - press_e[c] >= LONG);
                end else begin
                    m_long[c] <= 1'b0;
                    m_held[c] <= 1'b0;
                end
            end
        end
    end

    // scoreboard: every out-of-reset cycle, plus pulse tallies
    int long_seen [NCH];
    int rise_seen [NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            long_seen[c] = 0;
            rise_seen[c] = 0;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("model_out",  32'(button_out),  32'(m_out));
            chk("model_rise", 32'(button_rise), 32'(m_rise));
            chk("model_fall", 32'(button_fall), 32'(m_fall));
            chk("model_long", 32'(button_long), 32'(m_long));
            chk("model_held", 32'(button_held), 32'(m_held));
            chk("rise_fall_excl", 32'(button_rise & button_fall), 32'd0);
            for (int c = 0; c < NCH; c++) begin
                if (button_long[c]) long_seen[c]++;
                if (button_rise[c]) rise_seen[c]++;
            end
        end
    end

    // directed stimulus with literal expectations
    int lbase;
    int rbase;

    initial begin
        rst       = 1'b0;
        button_in = '0;
        #1;
        rst       = 1'b1;
        button_in = 3'b111;
        step(3);
        chk("reset_out",  32'(button_out),  32'd0);
        chk("reset_rise", 32'(button_rise), 32'd0);
        chk("reset_fall", 32'(button_fall), 32'd0);
        chk("reset_long", 32'(button_long), 32'd0);
        chk("reset_held", 32'(button_held), 32'd0);

        // release reset with all buttons held: cycle 0
        rst = 1'b0;
        step(9);
        chk("rel_out0_c9",  32'(button_out[0]), 32'd0);
        step(1);
        chk("rel_out0_c10", 32'(button_out[0]), 32'd1);
        chk("rel_rise0_c10", 32'(button_rise[0]), 32'd0);
        step(1);
        chk("rel_rise0_c11", 32'(button_rise[0]), 32'd1);
        step(1);
        chk("rel_rise0_c12", 32'(button_rise[0]), 32'd0);

        // drop after a ~12-cycle press
        button_in = 3'b000;
        step(9);
        chk("drop_out0_c9",  32'(button_out[0]), 32'd1);
        step(1);
        chk("drop_out0_c10", 32'(button_out[0]), 32'd0);
        chk("drop_fall0_c10", 32'(button_fall[0]), 32'd0);
        step(1);
        chk("drop_fall0_c11", 32'(button_fall[0]), 32'd1);
        chk("drop_rise0_c11", 32'(button_rise[0]), 32'd0);
        step(1);
        chk("drop_fall0_c12", 32'(button_fall[0]), 32'd0);
        chk("short_no_long2", 32'(long_seen[2]), 32'd0);
        step(5);

        // glitch on ch1: 5 cycles only
        rbase     = rise_seen[1];
        button_in = 3'b010;
        step(5);
        button_in = 3'b000;
        step(20);
        chk("glitch_out1",  32'(button_out[1]), 32'd0);
        chk("glitch_rise1", 32'(rise_seen[1] - rbase), 32'd0);

        // clean press on ch1
        button_in = 3'b010;
        step(9);
        chk("clean_out1_c9",  32'(button_out[1]), 32'd0);
        step(1);
        chk("clean_out1_c10", 32'(button_out[1]), 32'd1);
        button_in = 3'b000;
        step(20);

        // long press on ch2, 40 cycles
        lbase     = long_seen[2];
        button_in = 3'b100;
        step(10);
        chk("long_out2_up", 32'(button_out[2]), 32'd1);
        step(19);
        chk("long2_c19", 32'(button_long[2]), 32'd0);
        chk("held2_c19", 32'(button_held[2]), 32'd0);
        step(1);
        chk("long2_c20", 32'(button_long[2]), 32'd1);
        chk("held2_c20", 32'(button_held[2]), 32'd1);
        step(1);
        chk("long2_c21", 32'(button_long[2]), 32'd0);
        chk("held2_c21", 32'(button_held[2]), 32'd1);
        step(9);
        button_in = 3'b000;
        step(10);
        chk("long_out2_down", 32'(button_out[2]), 32'd0);
        chk("held2_at_fall",  32'(button_held[2]), 32'd1);
        step(1);
        chk("fall2_pulse", 32'(button_fall[2]), 32'd1);
        chk("held2_clear", 32'(button_held[2]), 32'd0);
        chk("long2_once",  32'(long_seen[2] - lbase), 32'd1);
        step(10);

        // simultaneous step on all channels
        button_in = 3'b111;
        step(10);
        chk("simul_rise_c10", 32'(button_rise), 32'd0);
        step(1);
        chk("simul_rise_c11", 32'(button_rise), 32'h7);
        step(1);
        chk("simul_rise_c12", 32'(button_rise), 32'd0);
        button_in = 3'b000;
        step(20);

        // reset while ch2 held and ch0 part-way through its count
        button_in = 3'b100;
        step(15);
        button_in = 3'b101;
        step(7);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out",  32'(button_out),  32'd0);
        chk("mid_rst_held", 32'(button_held), 32'd0);
        chk("mid_rst_rise", 32'(button_rise), 32'd0);
        step(1);
        rst = 1'b0;
        step(9);
        chk("mid_rel_out_c9",  32'(button_out), 32'd0);
        step(1);
        chk("mid_rel_out_c10", 32'(button_out), 32'h5);
        step(1);
        chk("mid_rel_rise_c11", 32'(button_rise), 32'h5);
        button_in = 3'b000;
        step(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- Parametrised N-channel push-button debouncer with a 2-FF input synchroniser per channel.
- Each channel provides a debounced level, one-cycle rise/fall pulses and a long-press event.
- Sits between board button pins and the game/menu control FSMs, and replaces the per-button single-channel 20 ms filters.
- Counters are per channel and clear explicitly; there is no free-running wrap.

Parameters:
- NUM_CH, 5, number of button channels (1..32).
- DEBOUNCE_CYCLES, 2_000_000, cycles the synchronised input must differ from the debounced level before the level flips (20 ms @ 100 MHz). Must be >= 2.
- LONG_CYCLES, 100_000_000, cycles the debounced level must stay pressed before a long-press event (1 s @ 100 MHz). Must be >= 2.
- RESET_LEVEL, 1'b0, debounced level loaded on reset; also the "released" value. Pressed = ~RESET_LEVEL.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- button_in, input, NUM_CH, raw asynchronous button pins.
- button_out, output, NUM_CH, debounced level per channel.
- button_rise, output, NUM_CH, one-cycle pulse when button_out goes 0->1.
- button_fall, output, NUM_CH, one-cycle pulse when button_out goes 1->0.
- button_long, output, NUM_CH, one-cycle pulse when a press has lasted LONG_CYCLES.
- button_held, output, NUM_CH, high from the long-press pulse until release.

Behaviour:
- Reset (async, rst=1):
  - sync stages and button_out := RESET_LEVEL.
  - All counters := 0.
  - button_rise, button_fall, button_long, button_held := 0.
- Synchroniser: s1 <= button_in; s2 <= s1. Only s2 is used downstream.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES)), per channel:
  - s2 == button_out: cnt <= 0.
  - s2 != button_out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != button_out and cnt == DEBOUNCE_CYCLES-1: button_out <= s2; cnt <= 0.
  - Any return of s2 to button_out before terminal count discards the progress (glitch rejection).
- Latency: a clean input step reaches button_out exactly 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
- Edge pulses: registered.
  - button_rise/button_fall assert in the cycle after button_out changes, for exactly one cycle.
  - Never both high in the same cycle on one channel.
- Long-press counter (width $clog2(LONG_CYCLES)+1):
  - Clears while button_out == RESET_LEVEL.
  - Increments while pressed; saturates at LONG_CYCLES.
  - Reaching LONG_CYCLES-1 -> LONG_CYCLES: button_long pulses one cycle (same registered timing as the edge pulses) and button_held sets.
  - Release (button_out returns to RESET_LEVEL) clears button_held in the same cycle button_fall is produced.
  - Only one button_long per press.
- Channels are fully independent. Simultaneous changes on several channels are handled in parallel with no priority.
- rst asserted mid-count: all state returns to reset values at once. After deassertion, a held button needs the full 2 + DEBOUNCE_CYCLES before button_out changes (no rise pulse is lost; it is regenerated).
- RESET_LEVEL=1 (active-low buttons): "pressed" means button_out==0. Long-press logic follows pressed. button_rise/button_fall still refer to literal level transitions.

Decomposition:
- Shared package btn_pkg:
  - CLK_HZ = 100_000_000.
  - DEBOUNCE_20MS = 2_000_000.
  - LONG_1S = 100_000_000.
  - Default NUM_CH = 5.
- One sub-module: debounce_channel, holding single-channel sync, counters and pulse logic with the same parameters minus NUM_CH.
- Top instantiates NUM_CH copies in a generate loop; no shared state.

Test Plan (bench uses NUM_CH=3, DEBOUNCE_CYCLES=8, LONG_CYCLES=20, RESET_LEVEL=0):
- Reset check: rst=1 with button_in=3'b111 -> all outputs 0. Release rst at cycle 0 -> button_out[0] rises at cycle 10, button_rise[0] pulses at cycle 11 only.
- Glitch rejection: ch1 high for 5 cycles then low -> button_out[1] stays 0 and no pulses. A later high held 8+ cycles -> rise after 10 cycles.
- Release: ch0 pressed then dropped -> button_out[0] falls 10 cycles after the drop; button_fall[0] lasts 1 cycle; button_rise[0] stays 0.
- Long press: ch2 held 40 cycles -> button_long[2] pulses once, 20 cycles after button_out[2] rises. button_held[2]=1 until release, then clears with the button_fall[2] pulse. A short 12-cycle press gives no long pulse.
- Simultaneous: all three channels step high in the same cycle -> three button_rise bits assert together in one cycle.
- Reset mid-operation: assert rst while ch0 is at cnt=5 and ch2 is held -> outputs 0 immediately. After deassertion, debounce restarts from 0 and the rise is seen 10 cycles later.
